// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the period and peak amplitude of a tone in an
// offset-binary sample stream, averaging 2^AVG_LOG2 periods per result.
//   clk, reset_n             sample clock, asynchronous active-low reset
//   din, din_valid           offset-binary sample and its qualifier
//   period_o                 averaged period in valid samples
//   peak_max_o, peak_min_o   extreme samples over the measurement window
//   amp_o                    peak_max_o - peak_min_o
//   meas_valid, meas_ready   result handshake toward the consumer
//   overrun                  sticky: a result was dropped while one was pending
//   no_signal                timeout occurred since the last good result
module tone_period_meter #(
   parameter int DATA_W   = 14,
   parameter int CNT_W    = 24,
   parameter int HYST     = 64,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 1048576
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic [CNT_W-1:0]  period_o,
   output logic [DATA_W-1:0] peak_max_o,
   output logic [DATA_W-1:0] peak_min_o,
   output logic [DATA_W-1:0] amp_o,
   output logic              meas_valid,
   input  logic              meas_ready,
   output logic              overrun,
   output logic              no_signal
);
   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam logic [DATA_W-1:0] MID   = DATA_W'(1 << (DATA_W - 1));
   localparam logic [DATA_W-1:0] HI_TH = MID + DATA_W'(HYST);
   localparam logic [DATA_W-1:0] LO_TH = MID - DATA_W'(HYST);

   typedef enum logic [1:0] {SEEK_LOW, ARM, WAIT_LOW, WAIT_HIGH} state_t;

   state_t              state;
   logic [DATA_W-1:0]   s_data;
   logic                s_valid;
   logic [CNT_W-1:0]    cnt, tcnt;
   logic [ACC_W-1:0]    acc;
   logic [AVG_LOG2:0]   idx;
   logic [DATA_W-1:0]   mx, mn;

   logic                is_low, is_high, done, publish, abort, xfer, accept;
   logic [CNT_W-1:0]    cnt_inc, tcnt_inc;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2:0]   idx_inc;
   logic [DATA_W-1:0]   mx_upd, mn_upd;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s_data  <= '0;
         s_valid <= 1'b0;
      end else begin
         s_data  <= din;
         s_valid <= din_valid;
      end

   always_comb begin
      is_low   = s_data < LO_TH;
      is_high  = s_data >= HI_TH;
      cnt_inc  = cnt + CNT_W'(1);
      tcnt_inc = tcnt + CNT_W'(1);
      idx_inc  = idx + (AVG_LOG2 + 1)'(1);
      acc_sum  = acc + ACC_W'(cnt_inc);
      mx_upd   = s_data > mx ? s_data : mx;
      mn_upd   = s_data < mn ? s_data : mn;
      done     = s_valid && state == WAIT_HIGH && is_high;
      // idx stays below 2^AVG_LOG2, so its top bit after increment marks a full window
      publish  = done && idx_inc[AVG_LOG2];
      // a completing period wins over a coincident timeout
      abort    = s_valid && !done && tcnt_inc == CNT_W'(TIMEOUT);
      xfer     = meas_valid && meas_ready;
      accept   = !meas_valid || meas_ready;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= SEEK_LOW;
         cnt        <= '0;
         tcnt       <= '0;
         acc        <= '0;
         idx        <= '0;
         mx         <= '0;
         mn         <= '1;
         period_o   <= '0;
         peak_max_o <= '0;
         peak_min_o <= '0;
         amp_o      <= '0;
         meas_valid <= 1'b0;
         overrun    <= 1'b0;
         no_signal  <= 1'b0;
      end else begin
         if (xfer) begin
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
         end
         if (publish) begin
            no_signal <= 1'b0;
            if (accept) begin
               period_o   <= CNT_W'(acc_sum >> AVG_LOG2);
               peak_max_o <= mx_upd;
               peak_min_o <= mn_upd;
               amp_o      <= mx_upd - mn_upd;
               meas_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
         if (abort) begin
            no_signal <= 1'b1;
            state     <= SEEK_LOW;
            cnt       <= '0;
            tcnt      <= '0;
            acc       <= '0;
            idx       <= '0;
            mx        <= '0;
            mn        <= '1;
         end else if (s_valid) begin
            tcnt <= tcnt_inc;
            case (state)
               SEEK_LOW: if (is_low) state <= ARM;
               ARM: if (is_high) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
                  acc   <= '0;
                  idx   <= '0;
                  mx    <= s_data;
                  mn    <= s_data;
               end
               WAIT_LOW: begin
                  cnt <= cnt_inc;
                  mx  <= mx_upd;
                  mn  <= mn_upd;
                  if (is_low) state <= WAIT_HIGH;
               end
               WAIT_HIGH: if (is_high) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
                  tcnt  <= '0;
                  acc   <= publish ? '0 : acc_sum;
                  idx   <= publish ? '0 : idx_inc;
                  // the completing sample also opens the next window
                  mx    <= publish ? s_data : mx_upd;
                  mn    <= publish ? s_data : mn_upd;
               end else begin
                  cnt <= cnt_inc;
                  mx  <= mx_upd;
                  mn  <= mn_upd;
               end
            endcase
         end
      end
endmodule
